// File: rtl/encoder16to4_queue.sv
// Queued 16-to-4 priority encoder: requests accumulate in a pending register and
// are presented one at a time on out/valid, retiring on ack.
module encoder16to4_queue #(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic        ack,
   output logic [3:0]  out,
   output logic        valid,
   output logic [15:0] pending
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t      state;
   logic [15:0] clr;
   logic [15:0] pending_next;
   logic [3:0]  enc_next;

   // Later matches overwrite earlier ones, so scan order sets the winner.
   function automatic logic [3:0] prio_enc(input logic [15:0] v);
      logic [3:0] idx;
      logic [3:0] j;
      idx = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         j = LOW_FIRST ? 4'(15 - i) : 4'(i);
         if (v[j]) idx = j;
      end
      return idx;
   endfunction

   always_comb begin
      clr = '0;
      if (valid && ack) clr[out] = 1'b1;
      pending_next = (pending & ~clr) | req;
      enc_next     = prio_enc(pending_next);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         valid   <= 1'b0;
         out     <= '0;
         pending <= '0;
      end else begin
         pending <= pending_next;
         case (state)
            IDLE: begin
               if (|pending_next) begin
                  state <= PRESENT;
                  valid <= 1'b1;
                  out   <= enc_next;
               end
            end
            PRESENT: begin
               // out stays frozen until the consumer takes it.
               if (ack) begin
                  if (|pending_next) begin
                     out <= enc_next;
                  end else begin
                     state <= IDLE;
                     valid <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder16to4_queue.sv
// Scoreboard bench for encoder16to4_queue: one instance per priority direction,
// directed scenarios followed by a randomized phase against a reference model.
module tb_encoder16to4_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] req;
   logic        ack;
   logic [3:0]  out_lo, out_hi;
   logic        valid_lo, valid_hi;
   logic [15:0] pending_lo, pending_hi;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   typedef struct {
      bit          hi;
      logic        v;
      logic [3:0]  o;
      logic [15:0] p;
   } exp_t;

   exp_t sb[$];

   logic        m_v[2];
   logic [3:0]  m_o[2];
   logic [15:0] m_p[2];

   encoder16to4_queue #(.LOW_FIRST(1'b1)) dut_lo (
      .clk(clk), .reset(reset), .req(req), .ack(ack),
      .out(out_lo), .valid(valid_lo), .pending(pending_lo)
   );

   encoder16to4_queue #(.LOW_FIRST(1'b0)) dut_hi (
      .clk(clk), .reset(reset), .req(req), .ack(ack),
      .out(out_hi), .valid(valid_hi), .pending(pending_hi)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push(input bit hi, input logic v, input logic [3:0] o, input logic [15:0] p);
      exp_t e;
      e.hi = hi; e.v = v; e.o = o; e.p = p;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.hi) begin
            check("hi_valid",   {15'b0, valid_hi}, {15'b0, e.v});
            check("hi_out",     {12'b0, out_hi},   {12'b0, e.o});
            check("hi_pending", pending_hi,        e.p);
         end else begin
            check("lo_valid",   {15'b0, valid_lo}, {15'b0, e.v});
            check("lo_out",     {12'b0, out_lo},   {12'b0, e.o});
            check("lo_pending", pending_lo,        e.p);
         end
      end
   endtask

   task automatic step_lo(input logic [15:0] r, input logic a,
                          input logic v, input logic [3:0] o, input logic [15:0] p);
      req = r; ack = a;
      push(1'b0, v, o, p);
      tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_lo_valid"}, {15'b0, valid_lo}, 16'h0);
      check({tag, "_lo_out"},   {12'b0, out_lo},   16'h0);
      check({tag, "_lo_pend"},  pending_lo,        16'h0);
      check({tag, "_hi_valid"}, {15'b0, valid_hi}, 16'h0);
      check({tag, "_hi_out"},   {12'b0, out_hi},   16'h0);
      check({tag, "_hi_pend"},  pending_hi,        16'h0);
   endtask

   task automatic sync_reset();
      reset = 1'b1; req = '0; ack = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic logic [3:0] ref_enc(input logic [15:0] v, input bit low_first);
      if (low_first) begin
         for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
      end else begin
         for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
      end
      return 4'h0;
   endfunction

   initial begin
      // Reset held across edges with requests/ack active: must stay cleared.
      reset = 1'b1; req = 16'hFFFF; ack = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check_zero("rst_hold");
      reset = 1'b0; req = '0; ack = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) step_lo(16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);

      // Burst 8421 with ack held high
      step_lo(16'h8421, 1'b1, 1'b1, 4'd0,  16'h8421);
      step_lo(16'h0000, 1'b1, 1'b1, 4'd5,  16'h8420);
      step_lo(16'h0000, 1'b1, 1'b1, 4'd10, 16'h8400);
      step_lo(16'h0000, 1'b1, 1'b1, 4'd15, 16'h8000);
      step_lo(16'h0000, 1'b1, 1'b0, 4'd15, 16'h0000);

      // Stable while valid despite higher-priority arrival
      step_lo(16'h0010, 1'b0, 1'b1, 4'd4, 16'h0010);
      step_lo(16'h0001, 1'b0, 1'b1, 4'd4, 16'h0011);
      step_lo(16'h0000, 1'b1, 1'b1, 4'd0, 16'h0001);
      step_lo(16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000);

      // Same-bit collision re-presents the index
      step_lo(16'h0008, 1'b0, 1'b1, 4'd3, 16'h0008);
      step_lo(16'h0008, 1'b1, 1'b1, 4'd3, 16'h0008);
      step_lo(16'h0000, 1'b1, 1'b0, 4'd3, 16'h0000);

      // ack while idle is ignored
      step_lo(16'h0000, 1'b1, 1'b0, 4'd3, 16'h0000);

      // Level-held request
      step_lo(16'h0006, 1'b1, 1'b1, 4'd1, 16'h0006);
      step_lo(16'h0006, 1'b1, 1'b1, 4'd1, 16'h0006);
      step_lo(16'h0000, 1'b1, 1'b1, 4'd2, 16'h0004);
      step_lo(16'h0000, 1'b1, 1'b0, 4'd2, 16'h0000);

      // Asynchronous reset mid-handshake
      step_lo(16'h00F0, 1'b0, 1'b1, 4'd4, 16'h00F0);
      req = '0; ack = 1'b1;
      #2 reset = 1'b1;
      #1 check_zero("async_rst");
      #1 reset = 1'b0;
      step_lo(16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000);

      // High-first sweep of all 16 lines
      sync_reset();
      req = 16'hFFFF; ack = 1'b1;
      push(1'b1, 1'b1, 4'd15, 16'hFFFF);
      tick();
      for (int k = 14; k >= 0; k--) begin
         req = '0; ack = 1'b1;
         push(1'b1, 1'b1, 4'(k), 16'((32'h1 << (k + 1)) - 1));
         tick();
      end
      req = '0; ack = 1'b1;
      push(1'b1, 1'b0, 4'd0, 16'h0000);
      tick();

      // Randomized traffic against the reference model, both directions
      sync_reset();
      for (int d = 0; d < 2; d++) begin
         m_v[d] = 1'b0; m_o[d] = '0; m_p[d] = '0;
      end
      for (int c = 0; c < 300; c++) begin
         logic [15:0] clr, pn;
         req = 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         ack = 1'($urandom_range(0, 1));
         for (int d = 0; d < 2; d++) begin
            clr = (m_v[d] && ack) ? (16'h1 << m_o[d]) : 16'h0;
            pn  = (m_p[d] & ~clr) | req;
            if (!m_v[d]) begin
               if (pn != 0) begin m_v[d] = 1'b1; m_o[d] = ref_enc(pn, d == 0); end
            end else if (ack) begin
               if (pn != 0) m_o[d] = ref_enc(pn, d == 0);
               else m_v[d] = 1'b0;
            end
            m_p[d] = pn;
            push(d == 1, m_v[d], m_o[d], m_p[d]);
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/encoder16to4_queue.md
ENCODER16TO4_QUEUE -- requirements
Module: encoder16to4_queue

Interface
REQ-001 Parameter: LOW_FIRST, default 1, priority direction; 1 = index 0 highest priority, 0 = index 15 highest priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  16  request lines, one per index, sampled every rising edge; a 1 marks that index pending.
REQ-005 ack  input  1  consumer accepts the presented index; meaningful only while valid=1.
REQ-006 out  output  4  binary index of the presented request; registered.
REQ-007 valid  output  1  out holds a pending index; registered.
REQ-008 pending  output  16  current pending-request register; registered.

Function
REQ-009 Pending update each edge: pending_next = (pending & ~clr) | req, where clr = one-hot(out) if (valid & ack), else 0.
REQ-010 Same-bit collision: req[i]=1 in the cycle index i is acked leaves pending[i]=1, so i is re-presented later.
REQ-011 FSM states: IDLE (valid=0) and PRESENT (valid=1).
REQ-012 IDLE -> PRESENT when pending_next != 0; out loads priority-encode(pending_next) on the same edge.
REQ-013 IDLE -> IDLE when pending_next == 0; out holds its last value.
REQ-014 PRESENT with ack=0: stay PRESENT; out holds even if a higher-priority req arrives (stable-while-valid rule).
REQ-015 PRESENT with ack=1 and pending_next != 0: stay PRESENT; out loads priority-encode(pending_next) on the same edge.
REQ-016 PRESENT with ack=1 and pending_next == 0: go to IDLE; valid=0 after the edge.
REQ-017 Latency: req[i] asserted before edge k, with the block idle and no other pending bits, gives valid=1 and out=i after edge k (1 cycle).
REQ-018 Throughput: ack held high with multiple bits pending retires one index per cycle, with no bubble cycles.
REQ-019 ack while valid=0 is ignored and has no effect on pending.
REQ-020 out is always a 4-bit index in 0..15; index wrap is not applicable; out is never X after reset.
REQ-021 Priority encode is exact: result is the lowest set index for LOW_FIRST=1 and the highest set index for LOW_FIRST=0.
REQ-022 Request lines are level-tolerant: holding req[i] high re-sets pending[i] every cycle, so i is re-presented after each ack.

Reset
REQ-023 Reset asserted clears all outputs immediately, independent of clk: pending=16'h0000, out=4'h0, valid=0, state=IDLE.
REQ-024 While reset=1, req and ack are ignored.
REQ-025 Reset mid-handshake (valid=1) drops the presented index and all pending bits without completing the ack.
REQ-026 First edge after reset deasserts samples req normally; with req=0 the block stays IDLE.

Verification
REQ-027 Reset then req=16'h0000 for 5 cycles -> valid=0, out=0, pending=0 throughout.
REQ-028 LOW_FIRST=1: single-cycle req=16'h8421, ack=1 continuously -> out sequence 0,5,10,15 on consecutive cycles with valid=1, then valid=0; pending ends at 0.
REQ-029 LOW_FIRST=1, ack=0: req=16'h0010 -> out=4; next cycle req=16'h0001 -> out stays 4 and pending=16'h0011; then ack=1 -> out=0 next cycle.
REQ-030 Collision: out=3, valid=1, ack=1 and req=16'h0008 in the same cycle -> pending[3] stays 1 and out=3 is presented again.
REQ-031 LOW_FIRST=0: single-cycle req=16'hFFFF, ack=1 continuously -> out sequence 15,14,...,0 over 16 cycles, then valid=0.
REQ-032 Reset pulse asynchronous to clk while pending=16'h00F0 and valid=1 -> all outputs 0 before the next edge; no ack effect after reset deasserts.
